// File: rtl/ccff_loader.sv
// ccff_loader: serializes config words onto the ccff chain, then recirculates it once for a CRC-8 integrity check
module ccff_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d, req_cnt_q, req_cnt_d, chk_cnt_q, chk_cnt_d;
  logic [BW-1:0]     buf_cnt_q, buf_cnt_d, take;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [7:0]        crc_tx_q, crc_tx_d, crc_rx_q, crc_rx_d;
  logic              err_q, err_d;
  logic [31:0]       rem;
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic d);
    return {c[6:0], 1'b0} ^ ((c[7] ^ d) ? 8'h07 : 8'h00);
  endfunction
  // next-state, datapath updates and chain-facing outputs
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    req_cnt_d     = req_cnt_q;
    chk_cnt_d     = chk_cnt_q;
    buf_cnt_d     = buf_cnt_q;
    buf_d         = buf_q;
    crc_tx_d      = crc_tx_q;
    crc_rx_d      = crc_rx_q;
    err_d         = err_q;
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    rem           = 32'(CHAIN_LEN) - 32'(req_cnt_q);
    take          = (rem < 32'(WORD_W)) ? BW'(rem) : BW'(WORD_W);
    unique case (state_q)
      IDLE, DONE: if (cfg_start) begin
        state_d   = LOAD;
        bit_cnt_d = '0;
        req_cnt_d = '0;
        buf_cnt_d = '0;
        crc_tx_d  = '0;
        crc_rx_d  = '0;
        err_d     = 1'b0;
      end
      LOAD: begin
        ccff_shift_en = buf_cnt_q != '0;
        ccff_head     = buf_q[WORD_W-1];
        cfg_ready     = (req_cnt_q < CW'(CHAIN_LEN)) && (buf_cnt_q <= BW'(1));
        if (ccff_shift_en) begin
          buf_d     = buf_q << 1;
          buf_cnt_d = buf_cnt_q - BW'(1);
          bit_cnt_d = bit_cnt_q + CW'(1);
          crc_tx_d  = crc_upd(crc_tx_q, ccff_head);
          if (bit_cnt_q == CW'(CHAIN_LEN - 1)) begin
            state_d   = CHECK;
            chk_cnt_d = CW'(CHAIN_LEN);
          end
        end
        if (cfg_valid && cfg_ready) begin
          buf_d     = cfg_data;
          buf_cnt_d = take;
          req_cnt_d = req_cnt_q + CW'(take);
        end
      end
      CHECK: begin
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        crc_rx_d      = crc_upd(crc_rx_q, ccff_tail);
        chk_cnt_d     = chk_cnt_q - CW'(1);
        if (chk_cnt_q == CW'(1)) begin
          state_d = DONE;
          err_d   = crc_rx_d != crc_tx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, async reset to an idle, quiet loader
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      req_cnt_q <= '0;
      chk_cnt_q <= '0;
      buf_cnt_q <= '0;
      buf_q     <= '0;
      crc_tx_q  <= '0;
      crc_rx_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      req_cnt_q <= req_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      buf_cnt_q <= buf_cnt_d;
      buf_q     <= buf_d;
      crc_tx_q  <= crc_tx_d;
      crc_rx_q  <= crc_rx_d;
      err_q     <= err_d;
    end
  end
  assign cfg_busy  = (state_q == LOAD) || (state_q == CHECK);
  assign cfg_done  = state_q == DONE;
  assign cfg_error = err_q;
endmodule
